// File: rtl/cpu_loader_pkg.sv
// Shared state encoding and address step constants for the CPU program loader.
// Each step is the byte stride between consecutive words of that memory.
package cpu_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDumpRd,
    StDumpCap,
    StDumpOut,
    StDone
  } state_e;

  localparam logic [63:0] IMEM_STEP = 64'd4;
  localparam logic [63:0] DMEM_STEP = 64'd8;

endpackage

// File: rtl/loader_out_buf.sv
// Holding register for dumped data words: presents one word with valid/last
// until the consumer accepts it.
module loader_out_buf (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic        load_last,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [63:0] out_data,
  output logic        out_last
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_last  <= load_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_loader.sv
// Session sequencer: streams a program into instruction memory, runs the CPU for
// a fixed number of cycles, then streams a block of data memory back out.
module cpu_loader
  import cpu_loader_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 512,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic [31:0] run_cycles,
  input  logic [10:0] dump_words,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2
);

  localparam int unsigned IW = $clog2(IMEM_WORDS + 1);
  localparam logic [IW-1:0] IMEM_TOP = IW'(IMEM_WORDS);
  localparam logic [10:0] DMEM_MAX = 11'(DMEM_WORDS);

  state_e        state_q;
  logic [IW-1:0] imem_idx_q;
  logic [10:0]   dump_idx_q;
  logic [10:0]   dump_words_q;
  logic [31:0]   run_cycles_q;
  logic [31:0]   run_cnt_q;
  logic          last_seen_q;
  logic          wen_q;
  logic [63:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          ren2_q;
  logic [63:0]   addr2_q;
  logic          enable_q;
  logic          done_q;

  logic          buf_load;
  logic          buf_last;
  logic          out_hs;

  assign busy        = (state_q != StIdle);
  assign in_ready    = (state_q == StLoad) && !last_seen_q && (imem_idx_q < IMEM_TOP);
  assign done        = done_q;
  assign enable      = enable_q;
  assign addr_ext    = addr_q;
  assign wen_ext     = wen_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_q;
  assign addr_ext_2  = addr2_q;
  assign wen_ext_2   = 1'b0;
  assign ren_ext_2   = ren2_q;
  assign wdata_ext_2 = '0;

  assign buf_load = (state_q == StDumpCap);
  assign buf_last = (dump_idx_q == dump_words_q - 11'd1);
  assign out_hs   = out_valid && out_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= StIdle;
      imem_idx_q   <= '0;
      dump_idx_q   <= '0;
      dump_words_q <= '0;
      run_cycles_q <= '0;
      run_cnt_q    <= '0;
      last_seen_q  <= 1'b0;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ren2_q       <= 1'b0;
      addr2_q      <= '0;
      enable_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      wen_q  <= 1'b0;
      ren2_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            run_cycles_q <= run_cycles;
            // Clamp so the dump index can never run past the data memory.
            dump_words_q <= (dump_words > DMEM_MAX) ? DMEM_MAX : dump_words;
            imem_idx_q   <= '0;
            last_seen_q  <= 1'b0;
            state_q      <= StLoad;
          end
        end
        StLoad: begin
          if (in_valid && in_ready) begin
            wen_q       <= 1'b1;
            addr_q      <= 64'(imem_idx_q) * IMEM_STEP;
            wdata_q     <= in_data;
            imem_idx_q  <= imem_idx_q + 1'b1;
            last_seen_q <= in_last;
          end
          // in_ready is low whenever this fires, so no handshake can collide.
          if (wen_q && (last_seen_q || (imem_idx_q == IMEM_TOP))) begin
            run_cnt_q <= run_cycles_q;
            enable_q  <= (run_cycles_q != 32'd0);
            state_q   <= StRun;
          end
        end
        StRun: begin
          if (run_cnt_q <= 32'd1) begin
            enable_q <= 1'b0;
            if (dump_words_q == 11'd0) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              dump_idx_q <= '0;
              ren2_q     <= 1'b1;
              addr2_q    <= '0;
              state_q    <= StDumpRd;
            end
          end else begin
            run_cnt_q <= run_cnt_q - 32'd1;
          end
        end
        StDumpRd: state_q <= StDumpCap;
        StDumpCap: state_q <= StDumpOut;
        StDumpOut: begin
          if (out_hs) begin
            if (out_last) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              dump_idx_q <= dump_idx_q + 11'd1;
              ren2_q     <= 1'b1;
              addr2_q    <= 64'(dump_idx_q + 11'd1) * DMEM_STEP;
              state_q    <= StDumpRd;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  loader_out_buf u_out_buf (
    .clk       (clk),
    .arst_n    (arst_n),
    .load      (buf_load),
    .load_data (rdata_ext_2),
    .load_last (buf_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule
